// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter: three producers share one register-file write port,
// with a scoreboard of claimed destination registers.
//
// Ports:
//   clk, reset    - clock and synchronous active-high reset
//   req_valid     - per-requester request (0 ALU, 1 load, 2 mul/div)
//   req_addr      - 5-bit destination register per requester
//   req_data      - 32-bit write data per requester
//   req_ready     - per-requester grant, at most one high per cycle
//   claim_valid   - issue stage marks claim_addr as pending
//   claim_addr    - register being claimed
//   write_en      - register-file write enable (one cycle after grant)
//   write_addr    - register-file write address (held when idle)
//   write_data    - register-file write data (held when idle)
//   busy_mask     - registers with an outstanding producer
//   err_unclaimed - sticky: a write landed on a register not marked busy
module reg_wb_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req_valid,
  input  logic [14:0] req_addr,
  input  logic [95:0] req_data,
  output logic [2:0]  req_ready,
  input  logic        claim_valid,
  input  logic [4:0]  claim_addr,
  output logic        write_en,
  output logic [4:0]  write_addr,
  output logic [31:0] write_data,
  output logic [31:0] busy_mask,
  output logic        err_unclaimed
);

  typedef enum logic [1:0] {
    P_ALU = 2'd0,
    P_LSU = 2'd1,
    P_MDU = 2'd2
  } ptr_e;

  ptr_e        ptr;
  ptr_e        ptr_nxt;
  logic [2:0]  gnt;
  logic        gnt_any;
  logic [4:0]  gnt_addr;
  logic [31:0] gnt_data;
  logic        wr_live;
  logic        claim_live;
  logic        err_hit;
  logic [31:0] busy_nxt;

  // Rotating priority starting at ptr.
  // Nothing is granted while reset is high.
  always_comb begin
    gnt = 3'b000;
    if (!reset) begin
      unique case (ptr)
        P_ALU: gnt = req_valid[0] ? 3'b001 :
                     req_valid[1] ? 3'b010 :
                     req_valid[2] ? 3'b100 : 3'b000;
        P_LSU: gnt = req_valid[1] ? 3'b010 :
                     req_valid[2] ? 3'b100 :
                     req_valid[0] ? 3'b001 : 3'b000;
        P_MDU: gnt = req_valid[2] ? 3'b100 :
                     req_valid[0] ? 3'b001 :
                     req_valid[1] ? 3'b010 : 3'b000;
        default: gnt = 3'b000;
      endcase
    end
  end

  assign req_ready = gnt;
  assign gnt_any   = |gnt;

  always_comb begin
    gnt_addr = 5'd0;
    gnt_data = 32'd0;
    ptr_nxt  = ptr;
    unique case (1'b1)
      gnt[0]: begin
        gnt_addr = req_addr[4:0];
        gnt_data = req_data[31:0];
        ptr_nxt  = P_LSU;
      end
      gnt[1]: begin
        gnt_addr = req_addr[9:5];
        gnt_data = req_data[63:32];
        ptr_nxt  = P_MDU;
      end
      gnt[2]: begin
        gnt_addr = req_addr[14:10];
        gnt_data = req_data[95:64];
        ptr_nxt  = P_ALU;
      end
      default: begin
        gnt_addr = 5'd0;
        gnt_data = 32'd0;
        ptr_nxt  = ptr;
      end
    endcase
  end

  // Register 0 transfers are accepted but never reach the file.
  assign wr_live    = gnt_any && (gnt_addr != 5'd0);
  assign claim_live = claim_valid && (claim_addr != 5'd0);

  // Clear first, then set: a same-cycle claim keeps the bit,
  // since the new producer is still outstanding.
  always_comb begin
    busy_nxt = busy_mask;
    if (wr_live)
      busy_nxt[gnt_addr] = 1'b0;
    if (claim_live)
      busy_nxt[claim_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  assign err_hit = wr_live
                && !busy_mask[gnt_addr]
                && !(claim_live && (claim_addr == gnt_addr));

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr           <= P_ALU;
      write_en      <= 1'b0;
      write_addr    <= 5'd0;
      write_data    <= 32'd0;
      busy_mask     <= 32'd0;
      err_unclaimed <= 1'b0;
    end else begin
      ptr       <= ptr_nxt;
      write_en  <= wr_live;
      if (wr_live) begin
        write_addr <= gnt_addr;
        write_data <= gnt_data;
      end
      busy_mask <= busy_nxt;
      if (err_hit)
        err_unclaimed <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter.
// Each task drives one scenario and checks its results inline.
module tb_reg_wb_arbiter;

  logic        clk;
  logic        reset;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        claim_valid;
  logic [4:0]  claim_addr;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [31:0] busy_mask;
  logic        err_unclaimed;

  int checks = 0;
  int errors = 0;

  reg_wb_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .claim_valid   (claim_valid),
    .claim_addr    (claim_addr),
    .write_en      (write_en),
    .write_addr    (write_addr),
    .write_data    (write_data),
    .busy_mask     (busy_mask),
    .err_unclaimed (err_unclaimed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_in();
    req_valid   = 3'b000;
    req_addr    = 15'd0;
    req_data    = 96'd0;
    claim_valid = 1'b0;
    claim_addr  = 5'd0;
  endtask

  task automatic set_req(input int i, input logic [4:0] a,
                         input logic [31:0] d);
    req_valid[i]       = 1'b1;
    req_addr[5*i +: 5] = a;
    req_data[32*i +: 32] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_in();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_in();
    reset = 1'b1;
    req_valid = 3'b111;
    step();
    step();
    checks++;
    if (req_ready !== 3'b000) begin
      errors++;
      $display("FAIL rst_ready: got %b exp 000", req_ready);
    end
    checks++;
    if (write_en !== 1'b0 || write_addr !== 5'd0 || write_data !== 32'd0) begin
      errors++;
      $display("FAIL rst_write: got en=%b a=%0d d=%h exp 0 0 0",
               write_en, write_addr, write_data);
    end
    checks++;
    if (busy_mask !== 32'd0 || err_unclaimed !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy_err: got %h %b exp 0 0",
               busy_mask, err_unclaimed);
    end
    clear_in();
    reset = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [2:0]  eg [4];
    logic [4:0]  ea [4];
    logic [31:0] ed [4];
    eg = '{3'b001, 3'b010, 3'b100, 3'b001};
    ea = '{5'd5, 5'd6, 5'd7, 5'd5};
    ed = '{32'h100, 32'h200, 32'h300, 32'h100};
    do_reset();
    set_req(0, 5'd5, 32'h100);
    set_req(1, 5'd6, 32'h200);
    set_req(2, 5'd7, 32'h300);
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (req_ready !== eg[k]) begin
        errors++;
        $display("FAIL rr_grant%0d: got %b exp %b", k, req_ready, eg[k]);
      end
      step();
      checks++;
      if (write_en !== 1'b1 || write_addr !== ea[k] || write_data !== ed[k]) begin
        errors++;
        $display("FAIL rr_write%0d: got en=%b a=%0d d=%h exp 1 %0d %h",
                 k, write_en, write_addr, write_data, ea[k], ed[k]);
      end
    end
    // Idle: pointer holds at 1, outputs hold.
    req_valid = 3'b000;
    #1;
    checks++;
    if (req_ready !== 3'b000) begin
      errors++;
      $display("FAIL rr_idle_ready: got %b exp 000", req_ready);
    end
    step();
    checks++;
    if (write_en !== 1'b0 || write_addr !== 5'd5 || write_data !== 32'h100) begin
      errors++;
      $display("FAIL rr_hold: got en=%b a=%0d d=%h exp 0 5 100",
               write_en, write_addr, write_data);
    end
    // Pointer at 1: only mul/div valid, then pointer wraps to 0.
    req_valid = 3'b100;
    #1;
    checks++;
    if (req_ready !== 3'b100) begin
      errors++;
      $display("FAIL rr_p1: got %b exp 100", req_ready);
    end
    step();
    req_valid = 3'b011;
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      errors++;
      $display("FAIL rr_wrap: got %b exp 001", req_ready);
    end
    checks++;
    if (err_unclaimed !== 1'b1) begin
      errors++;
      $display("FAIL rr_err: got %b exp 1", err_unclaimed);
    end
    step();
    clear_in();
  endtask

  task automatic test_claim_write();
    do_reset();
    claim_valid = 1'b1;
    claim_addr  = 5'd9;
    step();
    clear_in();
    checks++;
    if (busy_mask !== 32'h0000_0200) begin
      errors++;
      $display("FAIL cw_busy2: got %h exp 00000200", busy_mask);
    end
    step();
    set_req(1, 5'd9, 32'hDEADBEEF);
    #1;
    checks++;
    if (busy_mask[9] !== 1'b1 || req_ready !== 3'b010) begin
      errors++;
      $display("FAIL cw_cyc3: got busy9=%b rdy=%b exp 1 010",
               busy_mask[9], req_ready);
    end
    step();
    clear_in();
    checks++;
    if (write_en !== 1'b1 || write_addr !== 5'd9 || write_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL cw_write: got en=%b a=%0d d=%h exp 1 9 deadbeef",
               write_en, write_addr, write_data);
    end
    checks++;
    if (busy_mask !== 32'd0 || err_unclaimed !== 1'b0) begin
      errors++;
      $display("FAIL cw_clear: got %h %b exp 0 0", busy_mask, err_unclaimed);
    end
  endtask

  task automatic test_reg_zero();
    do_reset();
    set_req(0, 5'd0, 32'h1234);
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      errors++;
      $display("FAIL z_ready: got %b exp 001", req_ready);
    end
    step();
    clear_in();
    checks++;
    if (write_en !== 1'b0 || write_addr !== 5'd0 || write_data !== 32'd0) begin
      errors++;
      $display("FAIL z_write: got en=%b a=%0d d=%h exp 0 0 0",
               write_en, write_addr, write_data);
    end
    claim_valid = 1'b1;
    claim_addr  = 5'd0;
    step();
    clear_in();
    checks++;
    if (busy_mask !== 32'd0 || err_unclaimed !== 1'b0) begin
      errors++;
      $display("FAIL z_claim: got %h %b exp 0 0", busy_mask, err_unclaimed);
    end
  endtask

  task automatic test_claim_collision();
    do_reset();
    claim_valid = 1'b1;
    claim_addr  = 5'd4;
    step();
    set_req(2, 5'd4, 32'hCAFE0004);
    #1;
    checks++;
    if (req_ready !== 3'b100) begin
      errors++;
      $display("FAIL cc_ready: got %b exp 100", req_ready);
    end
    step();
    clear_in();
    checks++;
    if (write_en !== 1'b1 || write_addr !== 5'd4 || write_data !== 32'hCAFE0004) begin
      errors++;
      $display("FAIL cc_write: got en=%b a=%0d d=%h exp 1 4 cafe0004",
               write_en, write_addr, write_data);
    end
    checks++;
    if (busy_mask !== 32'h10 || err_unclaimed !== 1'b0) begin
      errors++;
      $display("FAIL cc_busy: got %h %b exp 00000010 0",
               busy_mask, err_unclaimed);
    end
    // Second producer now completes without a new claim.
    set_req(2, 5'd4, 32'h44);
    step();
    clear_in();
    checks++;
    if (busy_mask !== 32'd0 || err_unclaimed !== 1'b0) begin
      errors++;
      $display("FAIL cc_done: got %h %b exp 0 0", busy_mask, err_unclaimed);
    end
  endtask

  task automatic test_unclaimed();
    do_reset();
    set_req(0, 5'd12, 32'h0C0C);
    step();
    clear_in();
    checks++;
    if (write_en !== 1'b1 || write_addr !== 5'd12 || err_unclaimed !== 1'b1) begin
      errors++;
      $display("FAIL uc_write: got en=%b a=%0d err=%b exp 1 12 1",
               write_en, write_addr, err_unclaimed);
    end
    step();
    step();
    checks++;
    if (err_unclaimed !== 1'b1 || write_en !== 1'b0) begin
      errors++;
      $display("FAIL uc_sticky: got err=%b en=%b exp 1 0",
               err_unclaimed, write_en);
    end
  endtask

  task automatic test_reset_drop();
    do_reset();
    set_req(1, 5'd3, 32'h33);
    #1;
    checks++;
    if (req_ready !== 3'b010) begin
      errors++;
      $display("FAIL rd_grant: got %b exp 010", req_ready);
    end
    step();
    reset = 1'b1;
    set_req(0, 5'd1, 32'h11);
    set_req(2, 5'd2, 32'h22);
    #1;
    checks++;
    if (req_ready !== 3'b000) begin
      errors++;
      $display("FAIL rd_ready_rst: got %b exp 000", req_ready);
    end
    step();
    checks++;
    if (write_en !== 1'b0 || busy_mask !== 32'd0 || err_unclaimed !== 1'b0) begin
      errors++;
      $display("FAIL rd_drop: got en=%b busy=%h err=%b exp 0 0 0",
               write_en, busy_mask, err_unclaimed);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      errors++;
      $display("FAIL rd_ptr: got %b exp 001", req_ready);
    end
    step();
    clear_in();
  endtask

  initial begin
    reset = 1'b1;
    clear_in();
    test_reset();
    test_round_robin();
    test_claim_write();
    test_reg_zero();
    test_claim_collision();
    test_unclaimed();
    test_reset_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 Parameters: none; requester count fixed at 3, register count fixed at 32, data width fixed at 32.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 req_valid  input  3  per-requester writeback request (bit0 ALU, bit1 load unit, bit2 mul/div unit).
REQ-005 req_addr  input  15  per-requester destination register, 5 bits each, requester i at [5i+4:5i].
REQ-006 req_data  input  96  per-requester write data, 32 bits each, requester i at [32i+31:32i].
REQ-007 req_ready  output  3  per-requester grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-008 claim_valid  input  1  issue stage marks a destination register as pending.
REQ-009 claim_addr  input  5  register being claimed.
REQ-010 write_en  output  1  register-file write enable.
REQ-011 write_addr  output  5  register-file write address.
REQ-012 write_data  output  32  register-file write data.
REQ-013 busy_mask  output  32  bit r high = register r has a claimed, not yet written result.
REQ-014 err_unclaimed  output  1  sticky flag: a write was accepted to a register that was not busy.

Function
REQ-015 The block SHALL grant at most one requester per cycle; req_ready SHALL be combinational from req_valid and the round-robin pointer, and req_ready[i] SHALL never be high when req_valid[i] is low.
REQ-016 Arbitration SHALL be round-robin: search starts at pointer p (0..2) and wraps 2->0; the first valid requester wins.
REQ-017 After a grant to requester g, p SHALL become (g+1) mod 3; p SHALL be unchanged when nothing is granted.
REQ-018 Any continuously valid requester SHALL be granted within 3 cycles of raising req_valid.
REQ-019 Writeback latency SHALL be 1 cycle: a transfer in cycle N drives write_en=1 with that requester's address and data in cycle N+1; write_en SHALL be 0 in cycles following no transfer.
REQ-020 A transfer to register 0 SHALL be accepted (req_ready high) but SHALL produce write_en=0, preserving $zero.
REQ-021 write_addr and write_data SHALL hold their last values when write_en=0.
REQ-022 busy_mask[r] SHALL set in the cycle after claim_valid with claim_addr=r, for r!=0; claims of register 0 SHALL be ignored and busy_mask[0] SHALL always be 0.
REQ-023 busy_mask[r] SHALL clear in the cycle after a transfer with destination r.
REQ-024 A claim and a transfer to the same register in the same cycle SHALL leave the bit set (claim wins: the new producer remains outstanding).
REQ-025 A transfer with destination r!=0 while busy_mask[r]=0 and no same-cycle claim of r SHALL set err_unclaimed the next cycle; the write SHALL still be performed.
REQ-026 err_unclaimed SHALL remain high until reset.
REQ-027 Claims SHALL never stall; re-claiming an already busy register SHALL leave it busy.

Reset
REQ-028 While reset is high on a clock edge: p<=0, write_en<=0, write_addr<=0, write_data<=0, busy_mask<=0, err_unclaimed<=0.
REQ-029 During a reset cycle req_ready SHALL be all zero and no transfer or claim SHALL be recorded.
REQ-030 A transfer granted in the cycle before reset asserts SHALL be dropped: write_en SHALL be 0 in the cycle after the reset edge.

Verification
REQ-031 Reset, then req_valid=3'b111 held with addrs 5,6,7 -> grants in order bits 0,1,2,0 over 4 cycles; write_en with write_addr 5,6,7,5 one cycle later each.
REQ-032 claim_addr=9 in cycle 1, load unit writes reg 9 data 0xDEADBEEF in cycle 3 -> busy_mask[9]=1 in cycles 2..3, write_en/addr 9/data 0xDEADBEEF and busy_mask[9]=0 in cycle 4, err_unclaimed=0.
REQ-033 ALU writes reg 0 data 0x1234 -> req_ready[0]=1, write_en stays 0; claim of reg 0 -> busy_mask stays 0.
REQ-034 Same-cycle claim of reg 4 and mul/div write of reg 4 (reg 4 previously busy) -> write performed next cycle, busy_mask[4] remains 1, err_unclaimed=0.
REQ-035 Write to reg 12 with no prior claim -> write performed, err_unclaimed=1 next cycle and held until reset.
REQ-036 Transfer of reg 3 granted, reset asserted the next edge -> write_en=0, busy_mask=0, next grant with all requesters valid goes to bit 0.
